instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 36 +++
 rtl/instr_fetch.sv | 94 +++++++++
 tb/tb_instr_fetch.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage of the 16-bit stack
// processor: field widths, opcode/immediate positions, FSM encoding,
// reset PC and small PC helpers.
package instr_fetch_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSN_W  = 16;
   localparam int IMM_W   = 12;
   localparam int OPC_W   = INSN_W - IMM_W;

   // Field positions inside the instruction register
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int IMM_MSB = 11;

   // Bit 0 must be zero: fetches are always word aligned
   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   // Fetch FSM encoding
   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   // Next sequential word address; wraps modulo 2^ADDR_W with no flag
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(2);
   endfunction

   // Forces a byte address onto a word boundary
   function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] pc);
      return pc & ~ADDR_W'(1);
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues word requests to instruction
// memory (req/ack), latches returned words into the IR and hands them to
// decode with a valid/ready handshake. Redirects restart fetching at a new
// word-aligned address and drop any data returned in the same cycle.
module instr_fetch
   import instr_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [INSN_W-1:0] mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              insn_valid,
   input  logic              insn_ready,
   output logic [OPC_W-1:0]  opcode,
   output logic [IMM_W-1:0]  imm,
   output logic [ADDR_W-1:0] insn_pc
);

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] w_fetch_pc_nxt;
   logic [INSN_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_insn_pc;
   logic              w_load_ir;

   // State register; reset dominates every other input
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      if (reset) r_state <= S_RST;
      else       r_state <= w_state_nxt;
   end

   // Next-state, PC update and IR load decision
   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no
      // latch is inferred.
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_load_ir      = 1'b0;

      unique case (r_state)
         S_RST: w_state_nxt = S_REQ;
         S_REQ: begin
            if (mem_ack) begin
               w_load_ir      = 1'b1;
               w_fetch_pc_nxt = pc_inc(r_fetch_pc);
               w_state_nxt    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (insn_ready) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_RST;
      endcase

      // A redirect overrides the normal flow: data acked in the same cycle
      // is dropped and any held instruction is abandoned.
      if (redirect && (r_state != S_RST)) begin
         w_load_ir      = 1'b0;
         w_fetch_pc_nxt = pc_align(redirect_pc);
         w_state_nxt    = S_REQ;
      end
   end

   // Fetch PC, instruction register and its source address
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_ir       <= '0;
         r_insn_pc  <= RESET_PC;
      end else begin
         r_fetch_pc <= w_fetch_pc_nxt;
         if (w_load_ir) begin
            r_ir      <= mem_rdata;
            r_insn_pc <= r_fetch_pc;
         end
      end
   end

   // Outputs are decoded from registered state only
   assign mem_req    = (r_state == S_REQ);
   assign mem_addr   = r_fetch_pc;
   assign insn_valid = (r_state == S_HOLD);
   assign opcode     = r_ir[OPC_MSB:OPC_LSB];
   assign imm        = r_ir[IMM_MSB:0];
   assign insn_pc    = r_insn_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a linear sequence of cycle steps with
// hand-computed expectations checked by immediate assertions.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic              clk;
   logic              reset;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [INSN_W-1:0] mem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              insn_valid;
   logic              insn_ready;
   logic [OPC_W-1:0]  opcode;
   logic [IMM_W-1:0]  imm;
   logic [ADDR_W-1:0] insn_pc;

   int checks = 0;
   int errors = 0;

   instr_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .insn_valid  (insn_valid),
      .insn_ready  (insn_ready),
      .opcode      (opcode),
      .imm         (imm),
      .insn_pc     (insn_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full view of the decode-side outputs
   task automatic check_insn(input string tag, input logic v, input logic [3:0] op,
                             input logic [11:0] im, input logic [15:0] pc);
      check({tag, ".valid"},   16'(insn_valid), 16'(v));
      check({tag, ".opcode"},  16'(opcode),     16'(op));
      check({tag, ".imm"},     16'(imm),        16'(im));
      check({tag, ".insn_pc"}, insn_pc,         pc);
   endtask

   task automatic check_mem(input string tag, input logic rq, input logic [15:0] a);
      check({tag, ".mem_req"},  16'(mem_req), 16'(rq));
      check({tag, ".mem_addr"}, mem_addr,     a);
   endtask

   initial begin
      logic [15:0] sext;
      reset       = 1'b1;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      insn_ready  = 1'b0;

      // Reset state
      step();
      step();
      check_mem("rst", 1'b0, 16'h0000);
      check_insn("rst", 1'b0, 4'h0, 12'h000, 16'h0000);

      // First cycle after release is RST: still idle
      reset = 1'b0;
      #1;
      check_mem("rst_idle", 1'b0, 16'h0000);

      // REQ at address 0, zero-wait ack with 16'hA800
      step();
      check_mem("req0", 1'b1, 16'h0000);
      check("req0.valid", 16'(insn_valid), 16'h0000);
      mem_ack   = 1'b1;
      mem_rdata = 16'hA800;
      step();
      mem_ack = 1'b0;
      check_insn("hold0", 1'b1, 4'hA, 12'h800, 16'h0000);
      check("hold0.mem_req", 16'(mem_req), 16'h0000);
      sext = {{4{imm[11]}}, imm};
      check("hold0.sext", sext, 16'hF800);

      // Decode stalls 5 cycles: everything stable, no request
      for (int i = 0; i < 5; i++) begin
         step();
         check_insn("stall", 1'b1, 4'hA, 12'h800, 16'h0000);
         check("stall.mem_req", 16'(mem_req), 16'h0000);
      end

      // Accept: next request at 2
      insn_ready = 1'b1;
      step();
      insn_ready = 1'b0;
      check_mem("req1", 1'b1, 16'h0002);
      check("req1.valid", 16'(insn_valid), 16'h0000);

      // Three wait states: request held, IR untouched
      mem_rdata = 16'h5ABC;
      for (int i = 0; i < 3; i++) begin
         step();
         check_mem("wait", 1'b1, 16'h0002);
         check_insn("wait", 1'b0, 4'hA, 12'h800, 16'h0000);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check_insn("hold1", 1'b1, 4'h5, 12'hABC, 16'h0002);

      // Move to REQ at 4, then redirect to 16'h1235 alongside the ack
      insn_ready = 1'b1;
      step();
      insn_ready = 1'b0;
      check_mem("req2", 1'b1, 16'h0004);
      mem_ack     = 1'b1;
      mem_rdata   = 16'h7777;
      redirect    = 1'b1;
      redirect_pc = 16'h1235;
      step();
      redirect = 1'b0;
      check_mem("redir", 1'b1, 16'h1234);
      check_insn("redir", 1'b0, 4'h5, 12'hABC, 16'h0002);
      mem_rdata = 16'h3456;
      step();
      mem_ack = 1'b0;
      check_insn("hold_redir", 1'b1, 4'h3, 12'h456, 16'h1234);

      // Redirect from HOLD to 16'hFFFE, then fetch across the wrap
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      step();
      redirect = 1'b0;
      check_mem("redir_ff", 1'b1, 16'hFFFE);
      check("redir_ff.valid", 16'(insn_valid), 16'h0000);
      mem_ack   = 1'b1;
      mem_rdata = 16'h1001;
      step();
      mem_ack = 1'b0;
      check_insn("hold_ff", 1'b1, 4'h1, 12'h001, 16'hFFFE);
      insn_ready = 1'b1;
      step();
      insn_ready = 1'b0;
      check_mem("wrap", 1'b1, 16'h0000);
      mem_ack   = 1'b1;
      mem_rdata = 16'h2002;
      step();
      mem_ack = 1'b0;
      check_insn("hold_wrap", 1'b1, 4'h2, 12'h002, 16'h0000);

      // Reset in HOLD with an ack pulse: everything returns to reset values
      reset     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 16'hFFFF;
      step();
      reset   = 1'b0;
      mem_ack = 1'b0;
      check_mem("rst2", 1'b0, 16'h0000);
      check_insn("rst2", 1'b0, 4'h0, 12'h000, 16'h0000);
      step();
      check_mem("resume", 1'b1, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
